// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Purpose:
//   Arbitrates between an ALU writeback port and a load (MEM) writeback port
//   for a single register-file write port. The arbiter alternates priority
//   after every grant. It also keeps a pending-write scoreboard (busy),
//   which decode uses for hazard checks, and a counter of committed writes.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   alu_valid/addr/data, ready   ALU writeback request and accept
//   mem_valid/addr/data, ready   load writeback request and accept
//   rf_we/rf_waddr/rf_wdata      registered register-file write port
//   alloc_en/alloc_addr          issue stage marks a destination pending
//   raddr1/raddr2                decode source registers
//   hazard1/hazard2              busy bit of raddr1/raddr2 (combinational)
//   busy                         pending-write scoreboard
//   commit_cnt                   number of committed register writes
//
// Parameter:
//   ZERO_REG_WRITABLE  0: register 0 is hardwired. Writes to it are
//                      consumed without effect and it is never marked busy.
// ---------------------------------------------------------------------------
module regfile_wb_arbiter #(
  parameter bit ZERO_REG_WRITABLE = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_addr,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        mem_valid,
  input  logic [4:0]  mem_addr,
  input  logic [31:0] mem_data,
  output logic        mem_ready,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  input  logic        alloc_en,
  input  logic [4:0]  alloc_addr,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic        hazard1,
  output logic        hazard2,
  output logic [31:0] busy,
  output logic [15:0] commit_cnt
);

  typedef enum logic {
    PRI_ALU = 1'b0,
    PRI_MEM = 1'b1
  } pri_e;

  pri_e        pri_q, pri_d;
  logic        rf_we_q, rf_we_d;
  logic [4:0]  rf_waddr_q, rf_waddr_d;
  logic [31:0] rf_wdata_q, rf_wdata_d;
  logic [31:0] busy_q, busy_d;
  logic [15:0] commit_cnt_q, commit_cnt_d;

  logic        alu_grant;
  logic        mem_grant;
  logic        accept;
  logic [4:0]  acc_addr;
  logic [31:0] acc_data;
  logic        wr_effect;

  // Grant logic. A lone requester always wins. On contention the priority
  // state decides. Nothing is granted while reset is held.
  always_comb begin
    alu_grant = 1'b0;
    mem_grant = 1'b0;
    if (!rst) begin
      if (alu_valid && mem_valid) begin
        alu_grant = (pri_q == PRI_ALU);
        mem_grant = (pri_q == PRI_MEM);
      end else begin
        alu_grant = alu_valid;
        mem_grant = mem_valid;
      end
    end
  end

  assign alu_ready = alu_grant;
  assign mem_ready = mem_grant;

  assign accept   = alu_grant | mem_grant;
  assign acc_addr = mem_grant ? mem_addr : alu_addr;
  assign acc_data = mem_grant ? mem_data : alu_data;

  // A request to a hardwired r0 is still consumed (and still flips priority),
  // but it produces no register-file write and no commit.
  assign wr_effect = accept && (ZERO_REG_WRITABLE || (acc_addr != 5'd0));

  always_comb begin
    pri_d        = pri_q;
    rf_we_d      = wr_effect;
    rf_waddr_d   = rf_waddr_q;
    rf_wdata_d   = rf_wdata_q;
    commit_cnt_d = commit_cnt_q;
    if (alu_grant) begin
      pri_d = PRI_MEM;
    end else if (mem_grant) begin
      pri_d = PRI_ALU;
    end
    if (wr_effect) begin
      rf_waddr_d   = acc_addr;
      rf_wdata_d   = acc_data;
      commit_cnt_d = commit_cnt_q + 16'd1;
    end
  end

  // Per-register scoreboard update. An allocation on the same edge as a
  // writeback to the same register belongs to a newer instruction, so set
  // takes precedence over clear.
  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_busy
      localparam logic [4:0] IDX = 5'(gi);
      if ((gi == 0) && !ZERO_REG_WRITABLE) begin : g_zero
        assign busy_d[gi] = 1'b0;
      end else begin : g_reg
        assign busy_d[gi] = (alloc_en && (alloc_addr == IDX)) ? 1'b1 :
                            (accept   && (acc_addr   == IDX)) ? 1'b0 :
                            busy_q[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pri_q        <= PRI_ALU;
      rf_we_q      <= 1'b0;
      rf_waddr_q   <= 5'd0;
      rf_wdata_q   <= 32'd0;
      busy_q       <= 32'd0;
      commit_cnt_q <= 16'd0;
    end else begin
      pri_q        <= pri_d;
      rf_we_q      <= rf_we_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
      busy_q       <= busy_d;
      commit_cnt_q <= commit_cnt_d;
    end
  end

  assign rf_we      = rf_we_q;
  assign rf_waddr   = rf_waddr_q;
  assign rf_wdata   = rf_wdata_q;
  assign busy       = busy_q;
  assign commit_cnt = commit_cnt_q;
  assign hazard1    = busy_q[raddr1];
  assign hazard2    = busy_q[raddr2];

endmodule
